multicycle_sequencer: RTL

- Multi-cycle control FSM for the RV32 core. Steps one instruction at a time through fetch, decode, execute, memory and writeback over a single shared memory port.
- Consumes the opcode from the instruction register, the branch comparison result and the memory ready handshake.
- Drives PC/IR/register-file write enables, memory requests and the datapath selects (alusrc, aluop, memreg, pc_sel).
- Sits between the instruction register and the datapath, replacing single-cycle combinational control with sequenced per-state control.

---
 rtl/multicycle_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 control sequencer: walks one instruction through
// FETCH, DECODE, EXEC, MEM and WB over a single shared memory port and
// decodes per-state datapath controls from the state and latched op class.
module multicycle_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       rf_we,
  output logic       alusrc,
  output logic [1:0] aluop,
  output logic       memreg,
  output logic       instr_done,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_I    = 3'd2,
    CLS_LD   = 3'd3,
    CLS_ST   = 3'd4,
    CLS_BR   = 3'd5
  } cls_e;

  // Last count value before the limit; a wait cycle seen here times out.
  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MEM_WAIT_MAX - 1);

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic              tmo_q, tmo_d;
  logic              retire_go;

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign timeout_err = tmo_q;
  assign retire_go   = start;

  // State, op class, wait counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= CLS_NONE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      tmo_q     <= tmo_d;
    end
  end

  // Next-state logic and per-state control decode.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q;
    tmo_d      = tmo_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    rf_we      = 1'b0;
    alusrc     = 1'b0;
    aluop      = 2'b00;
    memreg     = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else if (cnt_q == WaitLast) begin
          tmo_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        state_d = S_EXEC;
        case (opcode)
          7'h33:   cls_d = CLS_R;
          7'h13:   cls_d = CLS_I;
          7'h03:   cls_d = CLS_LD;
          7'h23:   cls_d = CLS_ST;
          7'h63:   cls_d = CLS_BR;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end

      S_EXEC: begin
        case (cls_q)
          CLS_R: begin
            aluop   = 2'b10;
            state_d = S_WB;
          end
          CLS_I: begin
            alusrc  = 1'b1;
            aluop   = 2'b10;
            state_d = S_WB;
          end
          CLS_LD, CLS_ST: begin
            alusrc  = 1'b1;
            cnt_d   = '0;
            state_d = S_MEM;
          end
          CLS_BR: begin
            aluop      = 2'b01;
            pc_we      = 1'b1;
            pc_sel     = br_taken;
            instr_done = 1'b1;
            cnt_d      = '0;
            state_d    = retire_go ? S_FETCH : S_IDLE;
          end
          default: state_d = S_HALT;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CLS_ST);
        alusrc  = 1'b1;
        if (mem_ready) begin
          cnt_d = '0;
          if (cls_q == CLS_ST) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = retire_go ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == WaitLast) begin
          tmo_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WB: begin
        rf_we      = 1'b1;
        memreg     = (cls_q == CLS_LD);
        pc_we      = 1'b1;
        instr_done = 1'b1;
        cnt_d      = '0;
        state_d    = retire_go ? S_FETCH : S_IDLE;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_HALT;
    endcase
  end

endmodule
